// File: rtl/traffic_request_conditioner_if.sv
// Request-side signal bundle between the request conditioner and the traffic
// light controller: raw field inputs and controller acknowledges in, latched requests out.
interface traffic_request_conditioner_if;
    logic       walk_button_raw;
    logic       sensor_raw;
    logic       walk_lamp;
    logic       side_green;
    logic       walk_button;
    logic       sensor;
    logic       wait_lamp;
    logic [3:0] walk_countdown;
    logic [7:0] served_count;

    modport slave (
        input  walk_button_raw, sensor_raw, walk_lamp, side_green,
        output walk_button, sensor, wait_lamp, walk_countdown, served_count
    );

    modport master (
        output walk_button_raw, sensor_raw, walk_lamp, side_green,
        input  walk_button, sensor, wait_lamp, walk_countdown, served_count
    );
endinterface

// File: rtl/traffic_request_conditioner.sv
// Conditions raw pedestrian button and vehicle sensor inputs into latched requests
// held until the controller acknowledges them; also drives WAIT, walk countdown and served count.
module traffic_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int WALK_TIME       = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    traffic_request_conditioner_if.slave   bus
);
    // Bit 0 carries the pedestrian button, bit 1 the vehicle sensor.
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      deb_q, deb_d;
    logic [1:0][3:0] cnt_q, cnt_d;
    logic            walk_lamp_q, side_green_q;
    logic            walk_q, walk_d;
    logic            sensor_q, sensor_d;
    logic [3:0]      countdown_q, countdown_d;
    logic [7:0]      served_q, served_d;
    logic            walk_ack, veh_ack, walk_rise;

    assign raw = {bus.sensor_raw, bus.walk_button_raw};

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == 4'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    assign walk_ack  = bus.walk_lamp & ~walk_lamp_q;
    assign veh_ack   = bus.side_green & ~side_green_q;
    assign walk_rise = deb_d[0] & ~deb_q[0];

    always_comb begin
        walk_d      = walk_q;
        sensor_d    = sensor_q;
        countdown_d = countdown_q;
        served_d    = served_q;

        // Acknowledge takes priority; a press seen while the walk lamp is lit is dropped.
        if (walk_ack)
            walk_d = 1'b0;
        else if (walk_rise && !bus.walk_lamp)
            walk_d = 1'b1;

        // A vehicle still present re-requests as soon as side green goes away.
        if (veh_ack || bus.side_green)
            sensor_d = 1'b0;
        else if (deb_q[1])
            sensor_d = 1'b1;

        if (walk_ack && walk_q && served_q != 8'hFF)
            served_d = served_q + 8'd1;

        if (!bus.walk_lamp)
            countdown_d = '0;
        else if (walk_ack)
            countdown_d = 4'(WALK_TIME);
        else if (countdown_q != '0)
            countdown_d = countdown_q - 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            cnt_q        <= '0;
            walk_lamp_q  <= 1'b0;
            side_green_q <= 1'b0;
            walk_q       <= 1'b0;
            sensor_q     <= 1'b0;
            countdown_q  <= '0;
            served_q     <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            walk_lamp_q  <= bus.walk_lamp;
            side_green_q <= bus.side_green;
            walk_q       <= walk_d;
            sensor_q     <= sensor_d;
            countdown_q  <= countdown_d;
            served_q     <= served_d;
        end
    end

    assign bus.walk_button    = walk_q;
    assign bus.wait_lamp      = walk_q;
    assign bus.sensor         = sensor_q;
    assign bus.walk_countdown = countdown_q;
    assign bus.served_count   = served_q;

endmodule

// File: doc/traffic_request_conditioner.md
Name: traffic_request_conditioner

Overview:
- Front end for the traffic light controller. It turns raw pedestrian push-button and vehicle loop-sensor signals into the clean, latched `walk_button` and `sensor` requests the controller consumes.
- Each request is held until the controller acknowledges it through its own outputs: `walk_lamp` for pedestrians, `side_green` for vehicles.
- It also drives a pedestrian WAIT indicator, a walk countdown and a served-request counter.
- Shares the controller's 1 s clock: one cycle is one second.

Parameters:
- DEBOUNCE_CYCLES, 2, consecutive stable cycles a synchronized input must hold before its debounced level changes (legal 1..15).
- WALK_TIME, 5, seconds loaded into walk_countdown when the walk lamp turns on (legal 1..15).

Ports:
- clk  input  1  system clock, 1 Hz, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- walk_button_raw  input  1  raw pedestrian push-button, asynchronous, may bounce.
- sensor_raw  input  1  raw side-street vehicle sensor, asynchronous, may bounce.
- walk_lamp  input  1  controller walk lamp; its rising edge is the walk acknowledge.
- side_green  input  1  controller side green; its rising edge is the vehicle acknowledge.
- walk_button  output  1  latched pedestrian request to the controller.
- sensor  output  1  latched vehicle request to the controller.
- wait_lamp  output  1  pedestrian WAIT indicator; equals walk_button.
- walk_countdown  output  4  seconds of walk remaining; 0 when not walking.
- served_count  output  8  saturating count of acknowledged walk requests.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously by design convention):
  - All outputs go to 0.
  - Synchronizers, debounced levels, debounce counters and the walk_lamp/side_green delay registers clear to 0.
- Reset asserted mid-operation discards any pending request and any countdown.
- Synchronizer: a 2-flop synchronizer on each raw input; walk_lamp and side_green are already synchronous and are not synchronized.
- Debounce, per input:
  - If the synchronized value differs from the debounced level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the value still differing, the debounced level takes the new value and the counter clears.
  - Any cycle in which the synchronized value equals the debounced level clears the counter.
  - Raw-to-debounced latency is 2+DEBOUNCE_CYCLES rising edges, which is 4 at the default.
  - Pulses shorter than DEBOUNCE_CYCLES synchronized cycles are rejected.
- Edge detection: walk_lamp and side_green are each registered once.
  - walk_ack = walk_lamp & ~walk_lamp_q.
  - veh_ack = side_green & ~side_green_q.
- Walk request latch:
  - Set on the same edge the debounced button rises 0->1, but only if walk_lamp=0 on that edge. Presses made while walking are ignored.
  - Cleared on the edge where walk_ack=1.
  - If set and clear occur together, clear wins.
  - Repeated presses while already pending have no effect.
  - walk_button and wait_lamp both equal the latch.
- Vehicle request latch:
  - Set on any edge where the debounced sensor is 1 and side_green=0.
  - Cleared on the edge where veh_ack=1; clear wins over set.
  - Once side_green falls, a vehicle still present re-sets the latch on the next edge.
  - While side_green=1 the latch stays 0.
- served_count increments on each walk_ack edge where the walk latch was 1, and saturates at 255.
- walk_countdown:
  - On a walk_ack edge it loads WALK_TIME.
  - On each later edge with walk_lamp=1 and count>0 it decrements by 1.
  - It holds at 0 while walk_lamp stays high.
  - It clears to 0 on any edge with walk_lamp=0.
  - A walk_lamp high for longer than WALK_TIME seconds shows 0 for the remainder.
- Outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset: hold rst_n=0 with both raw inputs high for 3 cycles -> all outputs 0; release -> walk_button rises exactly 4 edges after the first post-reset edge.
- Debounce reject: walk_button_raw glitch high for 1 cycle (default params) -> walk_button stays 0 and served_count stays 0.
- Walk handshake: press for 3 s -> walk_button=1 and wait_lamp=1 after 4 edges; drive walk_lamp high 10 s later -> walk_button=0 on the first edge, walk_countdown sequence 5,4,3,2,1,0 on successive edges, served_count=1; drop walk_lamp -> walk_countdown=0.
- Ignore during walk: press while walk_lamp=1 -> walk_button stays 0 after walk_lamp falls; served_count unchanged.
- Vehicle handshake: sensor_raw held high -> sensor=1; raise side_green for 5 s -> sensor=0 during green; drop side_green with sensor_raw still high -> sensor=1 on the next edge.
- Simultaneous set/ack plus saturation: debounced press edge coinciding with a walk_lamp rise -> walk_button ends at 0; 260 acknowledged requests -> served_count=255.
